mon_fail_collector: RTL

//  Collects fail events from the per-unit EXU/core monitors and sits directly downstream of them.

---
 rtl/mon_fail_collector_if.sv | 31 +++
 rtl/mon_fail_collector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mon_fail_collector_if.sv
// Monitor fail-event bus: per-source fail requests/acks plus the record stream out of the collector.
// The master modport is the collector side; the slave modport is the monitors plus the record consumer.
interface mon_fail_collector_if #(
  parameter int NUM_SRC = 4,
  parameter int TS_W    = 32
);
  logic [NUM_SRC-1:0] fail_req;
  logic [NUM_SRC-1:0] fail_ack;
  logic               rec_valid;
  logic               rec_ready;
  logic [3:0]         rec_src;
  logic [TS_W-1:0]    rec_stamp;

  modport master (
    input  fail_req,
    input  rec_ready,
    output fail_ack,
    output rec_valid,
    output rec_src,
    output rec_stamp
  );

  modport slave (
    output fail_req,
    output rec_ready,
    input  fail_ack,
    input  rec_valid,
    input  rec_src,
    input  rec_stamp
  );
endinterface

// File: rtl/mon_fail_collector.sv
// Arbitrates monitor fail requests into a {src, stamp} record FIFO and raises finish after a drain window.
// Ack is combinational in the grant cycle; records appear one cycle later; a full FIFO holds requesters off.
module mon_fail_collector #(
  parameter int NUM_SRC      = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_W         = 32,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 enable,
  mon_fail_collector_if.master bus,
  output logic                 fail_seen,
  output logic [3:0]           first_src,
  output logic                 finish_req,
  output logic [15:0]          stall_cnt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int DC_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DC_W-1:0]    dcnt;
  logic [DC_W-1:0]    dcnt_nxt;
  logic               seen_nxt;
  logic [3:0]         first_nxt;
  logic               finish_nxt;

  logic [TS_W-1:0]    stamp;
  logic [3:0]         mem_src   [FIFO_DEPTH];
  logic [TS_W-1:0]    mem_stamp [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [NUM_SRC-1:0] win_hot;
  logic [3:0]         win;
  logic               any_req;
  logic               full;
  logic               pop;
  logic               space;
  logic               push;
  logic               stall;
  logic               drained;

  // Lowest-index requester wins; win_hot is the matching one-hot ack vector.
  always_comb begin
    win_hot = '0;
    win     = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.fail_req[i] && !any_req) begin
        any_req    = 1'b1;
        win        = 4'(i);
        win_hot[i] = 1'b1;
      end
    end
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = (count != '0) && bus.rec_ready;
  assign space   = !full || pop;
  // rst_l gating keeps the combinational ack low while reset is asserted.
  assign push    = rst_l && enable && any_req && space;
  assign stall   = rst_l && enable && any_req && !space;
  assign drained = ((count - CNT_W'(pop)) == '0);

  assign bus.fail_ack  = push ? win_hot : '0;
  assign bus.rec_valid = (count != '0);
  assign bus.rec_src   = bus.rec_valid ? mem_src[rd_ptr]   : 4'd0;
  assign bus.rec_stamp = bus.rec_valid ? mem_stamp[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      stamp     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      stamp <= stamp + TS_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_src[wr_ptr]   <= win;
      mem_stamp[wr_ptr] <= stamp;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      dcnt       <= '0;
      fail_seen  <= 1'b0;
      first_src  <= '0;
      finish_req <= 1'b0;
    end else begin
      state      <= state_nxt;
      dcnt       <= dcnt_nxt;
      fail_seen  <= seen_nxt;
      first_src  <= first_nxt;
      finish_req <= finish_nxt;
    end
  end

  // The last drain cycle (dcnt==0) doubles as the first empty check, so an
  // already-empty FIFO finishes exactly DRAIN_CYCLES cycles after the first grant.
  always_comb begin
    state_nxt  = state;
    dcnt_nxt   = dcnt;
    seen_nxt   = fail_seen;
    first_nxt  = first_src;
    finish_nxt = finish_req;
    case (state)
      IDLE: begin
        if (push) begin
          seen_nxt  = 1'b1;
          first_nxt = win;
          dcnt_nxt  = DC_W'(DRAIN_CYCLES - 1);
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt == '0) begin
          if (drained) begin
            state_nxt  = FINISH;
            finish_nxt = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end else begin
          dcnt_nxt = dcnt - DC_W'(1);
        end
      end
      WAIT: begin
        if (drained) begin
          state_nxt  = FINISH;
          finish_nxt = 1'b1;
        end
      end
      FINISH: begin
        finish_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
endmodule
